breadboard_sequencer: RTL and testbench

BREADBOARD_SEQUENCER -- requirements
Module: breadboard_sequencer

---
 rtl/breadboard_sequencer.sv | 142 ++++++++++++++
 tb/tb_breadboard_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/breadboard_sequencer.sv
// Sequencer for a 4-input breadboard: it drives each row onto the breadboard inputs and
// waits a programmable settle time. It then captures the 10 breadboard outputs and folds them into an XOR signature.
module breadboard_sequencer #(
  parameter int SETTLE_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                mode,
  input  logic [3:0]          row_sel,
  input  logic [SETTLE_W-1:0] settle,
  input  logic                abort,
  output logic                bb_w,
  output logic                bb_x,
  output logic                bb_y,
  output logic                bb_z,
  input  logic [9:0]          bb_r,
  output logic [3:0]          row_out,
  output logic [9:0]          res_out,
  output logic                res_valid,
  output logic [9:0]          sig,
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    CAPTURE,
    DONE
  } state_t;

  localparam logic [SETTLE_W-1:0] SETTLE_ONE = SETTLE_W'(1);
  localparam logic [3:0]          LAST_ROW   = 4'd15;

  state_t              state;
  logic [3:0]          row;
  logic                mode_q;
  logic [SETTLE_W-1:0] settle_q;
  logic [SETTLE_W-1:0] cnt;
  logic                go_capture;

  // The row register drives the breadboard pins directly, so the pins hold the last row in DONE and IDLE.
  assign {bb_w, bb_x, bb_y, bb_z} = row;

  // Capture is registered on the edge that enters CAPTURE. An abort seen on that same edge suppresses the capture.
  always_comb begin
    go_capture = 1'b0;
    if (!abort) begin
      if (state == DRIVE && settle_q == '0)
        go_capture = 1'b1;
      else if (state == SETTLE && cnt == SETTLE_ONE)
        go_capture = 1'b1;
    end
  end

  // NOTE: all state and outputs use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: every register, including the datapath, is reset because reset must clear all outputs immediately.
      state     <= IDLE;
      row       <= '0;
      mode_q    <= 1'b0;
      settle_q  <= '0;
      cnt       <= '0;
      row_out   <= '0;
      res_out   <= '0;
      res_valid <= 1'b0;
      sig       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      done      <= 1'b0;

      if (go_capture) begin
        res_out   <= bb_r;
        row_out   <= row;
        sig       <= sig ^ bb_r;
        res_valid <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            mode_q   <= mode;
            row      <= mode ? row_sel : 4'd0;
            settle_q <= settle;
            sig      <= '0;
            busy     <= 1'b1;
            state    <= DRIVE;
          end
        end

        DRIVE: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt   <= settle_q;
            state <= (settle_q == '0) ? CAPTURE : SETTLE;
          end
        end

        SETTLE: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (cnt == SETTLE_ONE) begin
            cnt   <= '0;
            state <= CAPTURE;
          end else begin
            cnt <= cnt - SETTLE_ONE;
          end
        end

        CAPTURE: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (!mode_q && row != LAST_ROW) begin
            row   <= row + 4'd1;
            state <= DRIVE;
          end else begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end

        DONE: state <= IDLE;

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_breadboard_sequencer.sv
// Directed bench for breadboard_sequencer. A breadboard model feeds bb_r, and a scoreboard
// queue holds the expected captures and done pulses, each tagged with the cycle it is due in.
module tb_breadboard_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       mode;
  logic [3:0] row_sel;
  logic [3:0] settle;
  logic       abort;
  logic       bb_w, bb_x, bb_y, bb_z;
  logic [9:0] bb_r;
  logic [3:0] row_out;
  logic [9:0] res_out;
  logic       res_valid;
  logic [9:0] sig;
  logic       busy;
  logic       done;

  typedef struct {
    int         cyc;
    logic [3:0] row;
    logic [9:0] res;
  } cap_t;

  cap_t       exp_q[$];
  int         done_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         t0 = 0;
  bit         model_sel = 1'b0;
  logic [3:0] bb_row;

  breadboard_sequencer #(.SETTLE_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .row_sel(row_sel),
    .settle(settle), .abort(abort), .bb_w(bb_w), .bb_x(bb_x), .bb_y(bb_y),
    .bb_z(bb_z), .bb_r(bb_r), .row_out(row_out), .res_out(res_out),
    .res_valid(res_valid), .sig(sig), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [9:0] model(logic [3:0] r, bit sel);
    if (sel) return (r == 4'd7) ? 10'h3FF : 10'h000;
    return {6'b0, r};
  endfunction

  assign bb_row = {bb_w, bb_x, bb_y, bb_z};
  assign bb_r   = model(bb_row, model_sel);

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard side: compare every capture and done pulse against the queue head.
  always @(negedge clk) begin
    if (res_valid) begin
      if (exp_q.size() == 0) begin
        check("extra_res_valid", {31'b0, res_valid}, 32'd0);
      end else begin
        cap_t e;
        e = exp_q.pop_front();
        check("cap_cycle", cyc - t0, e.cyc);
        check("cap_row_out", {28'b0, row_out}, {28'b0, e.row});
        check("cap_res_out", {22'b0, res_out}, {22'b0, e.res});
      end
    end
    if (done) begin
      if (done_q.size() == 0) begin
        check("extra_done", {31'b0, done}, 32'd0);
      end else begin
        check("done_cycle", cyc - t0, done_q.pop_front());
        check("busy_in_done", {31'b0, busy}, 32'd0);
      end
    end
  end

  task automatic push_sweep(int s, bit sel);
    for (int n = 0; n < 16; n++)
      exp_q.push_back('{cyc: (n + 1) * (2 + s), row: 4'(n), res: model(4'(n), sel)});
    done_q.push_back(16 * (2 + s) + 1);
  endtask

  // Drives start for one cycle; returns at the negedge of cycle 1.
  task automatic run_start(bit m, logic [3:0] rs, logic [3:0] s);
    @(negedge clk);
    mode    = m;
    row_sel = rs;
    settle  = s;
    start   = 1'b1;
    t0      = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_cycle(int n);
    while (cyc - t0 < n) @(negedge clk);
  endtask

  task automatic wait_drain(int budget);
    int n = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", exp_q.size() + done_q.size(), 0);
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_row_out"}, {28'b0, row_out}, 32'd0);
    check({tag, "_res_out"}, {22'b0, res_out}, 32'd0);
    check({tag, "_sig"}, {22'b0, sig}, 32'd0);
    check({tag, "_bb"}, {28'b0, bb_row}, 32'd0);
    check({tag, "_flags"}, {29'b0, res_valid, busy, done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; row_sel = 4'd0; settle = 4'd0; abort = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_busy", {31'b0, busy}, 32'd0);

    // Full sweep, settle=0: captures in cycles 2,4,...,32 and done in cycle 33.
    model_sel = 1'b0;
    push_sweep(0, 1'b0);
    run_start(1'b0, 4'd9, 4'd0);
    check("sweep_busy_c1", {31'b0, busy}, 32'd1);
    check("sweep_bb_c1", {28'b0, bb_row}, 32'd0);
    wait_drain(60);
    @(negedge clk);
    check("sweep_busy_after", {31'b0, busy}, 32'd0);
    check("sweep_row_out", {28'b0, row_out}, 32'd15);
    check("sweep_bb_hold", {28'b0, bb_row}, 32'd15);
    check("sweep_sig", {22'b0, sig}, 32'd0);

    // Single row 5 with settle=3: capture in cycle 5 and done in cycle 6.
    exp_q.push_back('{cyc: 5, row: 4'd5, res: 10'd5});
    done_q.push_back(6);
    run_start(1'b1, 4'd5, 4'd3);
    check("single_bb_c1", {28'b0, bb_row}, 32'b0101);
    wait_drain(30);
    @(negedge clk);
    check("single_row_out", {28'b0, row_out}, 32'd5);
    check("single_sig", {22'b0, sig}, 32'd5);
    check("single_busy_after", {31'b0, busy}, 32'd0);

    // Signature: only row 7 returns 3FF, so the sweep signature is 3FF. A new run then restarts sig from zero.
    model_sel = 1'b1;
    push_sweep(1, 1'b1);
    run_start(1'b0, 4'd0, 4'd1);
    wait_drain(80);
    check("sig_sweep", {22'b0, sig}, 32'h3FF);
    exp_q.push_back('{cyc: 2, row: 4'd3, res: 10'h000});
    done_q.push_back(3);
    run_start(1'b1, 4'd3, 4'd0);
    check("sig_cleared_on_start", {22'b0, sig}, 32'd0);
    wait_drain(30);
    check("sig_second_run", {22'b0, sig}, 32'd0);

    // Abort in cycle 13 with settle=2: rows 0..2 are captured, the block is IDLE in cycle 14, and no done pulse follows.
    model_sel = 1'b0;
    for (int n = 0; n < 3; n++)
      exp_q.push_back('{cyc: 4 * (n + 1), row: 4'(n), res: 10'(n)});
    run_start(1'b0, 4'd0, 4'd2);
    wait_cycle(13);
    abort = 1'b1;
    wait_cycle(14);
    abort = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_row_out", {28'b0, row_out}, 32'd2);
    check("abort_res_out", {22'b0, res_out}, 32'd2);
    check("abort_sig", {22'b0, sig}, 32'd3);
    repeat (10) @(negedge clk);
    check("abort_pending", exp_q.size() + done_q.size(), 0);

    // A start pulse during SETTLE is ignored. Reset in SETTLE then clears everything at once.
    exp_q.push_back('{cyc: 5, row: 4'd0, res: 10'd0});
    exp_q.push_back('{cyc: 10, row: 4'd1, res: 10'd1});
    run_start(1'b0, 4'd0, 4'd3);
    wait_cycle(2);
    start = 1'b1;
    mode  = 1'b1;
    wait_cycle(3);
    start = 1'b0;
    mode  = 1'b0;
    wait_cycle(13);
    check("busy_before_rst", {31'b0, busy}, 32'd1);
    check("rst_pending", exp_q.size(), 0);
    #1 rst = 1'b1;
    #1;
    check_all_zero("midrun_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("post_rst_idle", {30'b0, busy, res_valid}, 32'd0);

    push_sweep(0, 1'b0);
    run_start(1'b0, 4'd0, 4'd0);
    wait_drain(60);
    @(negedge clk);
    check("resweep_row_out", {28'b0, row_out}, 32'd15);
    check("resweep_busy", {31'b0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
